// File: rtl/core_pkg.sv
// Shared core constants and the WB pipeline-register layout.
package core_pkg;

    localparam int XLEN = 32;

    // Result select encodings
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_RSVD = 2'd3;

    // Load width/sign encodings (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Fields held in the MEM/WB boundary register (valid kept separately)
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] mem_rdata;
        logic [4:0]      rd;
        logic            reg_we;
        logic [1:0]      wb_sel;
        logic [2:0]      funct3;
    } wb_reg_t;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension. Purely combinational so the
// load/store unit can reuse it. Halfword loads ignore off[0]; misaligned
// accesses are trapped before they reach this logic.
module load_extend
    import core_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/halfword, then extend per funct3
    always_comb begin
        byte_v = word[7:0];
        case (off)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB:   ext = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  ext = {24'd0, byte_v};
            F3_LH:   ext = {{16{half_v[15]}}, half_v};
            F3_LHU:  ext = {16'd0, half_v};
            default: ext = word;   // LW and anything unrecognised: raw word
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB boundary register, result select, register-file
// write port, bypass tap and retire pulse.
// Optional: define WB_INSTRET_EN to add a 64-bit retired-instruction counter.
module writeback_stage
    import core_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_we,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    output logic [4:0]      addr_rd,
    output logic [XLEN-1:0] data_rd,
    output logic            write_enable,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
`ifdef WB_INSTRET_EN
    output logic [63:0]     instret,
`endif
    output logic            retire
);

    logic      valid_q, valid_d;
    wb_reg_t   wb_q, wb_d;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] result;

    // Next-state for the boundary register: flush beats stall beats capture.
    // On flush the fields simply hold; only valid matters.
    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d           = in_valid;
            wb_d.pc           = in_pc;
            wb_d.alu_result   = in_alu_result;
            wb_d.mem_rdata    = in_mem_rdata;
            wb_d.rd           = in_rd;
            wb_d.reg_we       = in_reg_we;
            wb_d.wb_sel       = in_wb_sel;
            wb_d.funct3       = in_funct3;
        end
    end

    // Boundary register; reset drops any in-flight instruction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            wb_q    <= '{pc: RESET_PC, default: '0};
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
        end
    end

    load_extend u_load_extend (
        .funct3 (wb_q.funct3),
        .off    (wb_q.alu_result[1:0]),
        .word   (wb_q.mem_rdata),
        .ext    (load_val)
    );

    // Result select and write-port qualification. Writes stay asserted while
    // stalled: rewriting the same value is harmless to the register file.
    always_comb begin
        case (wb_q.wb_sel)
            WB_SEL_ALU:  result = wb_q.alu_result;
            WB_SEL_LOAD: result = load_val;
            WB_SEL_PC4:  result = wb_q.pc + 32'd4;
            default:     result = '0;
        endcase
        write_enable = valid_q && wb_q.reg_we && (wb_q.rd != 5'd0)
                       && (wb_q.wb_sel != WB_SEL_RSVD);
        addr_rd      = write_enable ? wb_q.rd : 5'd0;
        data_rd      = result;
        fwd_valid    = write_enable;
        fwd_rd       = addr_rd;
        fwd_data     = data_rd;
        // Retire as the instruction leaves WB; flush only kills the incoming one
        retire       = valid_q && !stall && (wb_q.wb_sel != WB_SEL_RSVD);
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Retired-instruction count, wraps naturally at 2^64
    always_comb begin
        instret_d = instret_q + {63'd0, retire};
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) instret_q <= 64'd0;
        else          instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; instret checks only when WB_INSTRET_EN.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall, flush, in_valid;
    logic [31:0] in_pc, in_alu_result, in_mem_rdata;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [4:0]  addr_rd, fwd_rd;
    logic [31:0] data_rd, fwd_data;
    logic        write_enable, fwd_valid, retire;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    writeback_stage dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_rd         (in_rd),
        .in_reg_we     (in_reg_we),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .addr_rd       (addr_rd),
        .data_rd       (data_rd),
        .write_enable  (write_enable),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
`ifdef WB_INSTRET_EN
        .instret       (instret),
`endif
        .retire        (retire)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic we,
                         input logic [1:0] sel, input logic [2:0] f3);
        in_valid = v; in_pc = pc; in_alu_result = alu; in_mem_rdata = rdata;
        in_rd = rd; in_reg_we = we; in_wb_sel = sel; in_funct3 = f3;
    endtask

    // advance one edge and settle away from it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // load vectors: funct3, offset, expected
    logic [2:0]  lf3 [8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b010};
    logic [1:0]  loff[8] = '{2'd2,   2'd1,   2'd3,   2'd3,   2'd2,   2'd3,   2'd0,   2'd1};
    logic [31:0] lexp[8] = '{32'hFFFF_FFFF, 32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080,
                             32'hFFFF_80FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h40, 32'hAAAA_AAAA, 32'h0, 5'd5, 1'b1, 2'd0, 3'd0);
        tick();
        tick();
        chk("rst_we",    {63'd0, write_enable}, 64'd0);
        chk("rst_data",  {32'd0, data_rd}, 64'd0);
        chk("rst_ret",   {63'd0, retire}, 64'd0);
        chk("rst_addr",  {59'd0, addr_rd}, 64'd0);
`ifdef WB_INSTRET_EN
        chk("rst_instret", instret, 64'd0);
`endif
        reset_n = 1'b1;
        drive(1'b1, 32'h100, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 2'd0, 3'd0);
        #2;
        chk("idle_we", {63'd0, write_enable}, 64'd0);

        // ALU write
        tick();
        chk("alu_addr", {59'd0, addr_rd}, 64'd5);
        chk("alu_data", {32'd0, data_rd}, 64'h1234_5678);
        chk("alu_we",   {63'd0, write_enable}, 64'd1);
        chk("alu_ret",  {63'd0, retire}, 64'd1);
        chk("alu_fwdv", {63'd0, fwd_valid}, 64'd1);
        chk("alu_fwdr", {59'd0, fwd_rd}, 64'd5);
        chk("alu_fwdd", {32'd0, fwd_data}, 64'h1234_5678);

        // load extension
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h104, 32'h0000_1000 | {30'd0, loff[i]}, 32'h80FF_7F01,
                  5'd6, 1'b1, 2'd1, lf3[i]);
            tick();
            chk($sformatf("load%0d", i), {32'd0, data_rd}, {32'd0, lexp[i]});
        end
        chk("load_we", {63'd0, write_enable}, 64'd1);

        // x0 destination
        drive(1'b1, 32'h108, 32'h0000_DEAD, 32'h0, 5'd0, 1'b1, 2'd0, 3'd0);
        tick();
        chk("x0_we",   {63'd0, write_enable}, 64'd0);
        chk("x0_addr", {59'd0, addr_rd}, 64'd0);
        chk("x0_ret",  {63'd0, retire}, 64'd1);

        // reserved select
        drive(1'b1, 32'h10C, 32'h0000_BEEF, 32'h0, 5'd3, 1'b1, 2'd3, 3'd0);
        tick();
        chk("rsv_we",   {63'd0, write_enable}, 64'd0);
        chk("rsv_ret",  {63'd0, retire}, 64'd0);
        chk("rsv_data", {32'd0, data_rd}, 64'd0);

        // valid, we=0: no write, still retires
        drive(1'b1, 32'h110, 32'h0000_0011, 32'h0, 5'd4, 1'b0, 2'd0, 3'd0);
        tick();
        chk("nowe_we",  {63'd0, write_enable}, 64'd0);
        chk("nowe_ret", {63'd0, retire}, 64'd1);

        // stall three cycles then flush with stall
        drive(1'b1, 32'h114, 32'h0000_0077, 32'h0, 5'd7, 1'b1, 2'd0, 3'd0);
        tick();
        chk("stl_cap_we", {63'd0, write_enable}, 64'd1);
        stall = 1'b1;
        drive(1'b1, 32'h118, 32'h0000_0099, 32'h0, 5'd9, 1'b1, 2'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            else #1;
            chk($sformatf("stl%0d_we", i),   {63'd0, write_enable}, 64'd1);
            chk($sformatf("stl%0d_addr", i), {59'd0, addr_rd}, 64'd7);
            chk($sformatf("stl%0d_data", i), {32'd0, data_rd}, 64'h77);
            chk($sformatf("stl%0d_ret", i),  {63'd0, retire}, 64'd0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0);
        #1;
        chk("fl_we",   {63'd0, write_enable}, 64'd0);
        chk("fl_fwdv", {63'd0, fwd_valid}, 64'd0);
        chk("fl_ret",  {63'd0, retire}, 64'd0);

        // flush without stall still retires the instruction in WB
        drive(1'b1, 32'h11C, 32'h0000_0055, 32'h0, 5'd8, 1'b1, 2'd0, 3'd0);
        tick();
        flush = 1'b1;
        #1;
        chk("flr_ret", {63'd0, retire}, 64'd1);
        tick();
        flush = 1'b0;
        chk("flr_we", {63'd0, write_enable}, 64'd0);

        // reset mid-operation drops the in-flight instruction
        drive(1'b1, 32'h120, 32'h0000_0066, 32'h0, 5'd10, 1'b1, 2'd0, 3'd0);
        tick();
        chk("mid_we_pre", {63'd0, write_enable}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_we",   {63'd0, write_enable}, 64'd0);
        chk("mid_ret",  {63'd0, retire}, 64'd0);
        chk("mid_data", {32'd0, data_rd}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // PC+4 wrap then four more back-to-back
        drive(1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd1, 1'b1, 2'd2, 3'd0);
        tick();
        chk("pc4_wrap", {32'd0, data_rd}, 64'd0);
        chk("pc4_we",   {63'd0, write_enable}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'h0, 32'h0, 5'd1, 1'b1, 2'd2, 3'd0);
            tick();
            chk($sformatf("pc4_%0d", i), {32'd0, data_rd}, {32'd0, 32'h204 + 32'(i * 4)});
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 3'd0);
        tick();
        chk("end_ret", {63'd0, retire}, 64'd0);
`ifdef WB_INSTRET_EN
        chk("instret", instret, 64'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
